// File: rtl/vxe_axi4mas_reqq.sv
// +----------------------------------------------------------------------------+
// | Module      : vxe_axi4mas_reqq                                             |
// | Description : Write/read request FIFOs feeding the AXI4 master BIU.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module vxe_axi4mas_reqq_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_POW2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_valid_o,
  output logic             empty_o,
  output logic             uflow_o
);

  localparam int unsigned          c_DEPTH    = 1 << DEPTH_POW2;
  localparam logic [DEPTH_POW2:0]  c_FULL_CNT = {1'b1, {DEPTH_POW2{1'b0}}};
  localparam logic [DEPTH_POW2:0]  c_CNT_ONE  = (DEPTH_POW2 + 1)'(1);
  localparam logic [DEPTH_POW2-1:0] c_PTR_ONE = DEPTH_POW2'(1);

  logic [WIDTH-1:0]      mem_q [c_DEPTH];
  logic [DEPTH_POW2-1:0] rptr_q, rptr_d;
  logic [DEPTH_POW2-1:0] wptr_q, wptr_d;
  logic [DEPTH_POW2:0]   cnt_q, cnt_d;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_full  = (cnt_q == c_FULL_CNT);
  assign w_empty = (cnt_q == '0);

  // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
  assign push_ready_o = !w_full && !rst;
  assign w_push       = push_valid_i && push_ready_o;
  assign w_pop        = pop_i && !w_empty;
  assign uflow_o      = pop_i && w_empty;

  // The BIU pops one cycle after sampling; masking avoids a duplicate issue.
  assign head_valid_o = !w_empty && !pop_i;
  assign head_data_o  = mem_q[rptr_q];
  assign empty_o      = w_empty;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (w_push) begin
      wptr_d = wptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rptr_d = rptr_q + c_PTR_ONE;
    end
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + c_CNT_ONE;
      2'b01:   cnt_d = cnt_q - c_CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(c_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (w_push) begin
        mem_q[wptr_q] <= push_data_i;
      end
    end
  end

endmodule

module vxe_axi4mas_reqq #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CID_WIDTH     = 8,
  parameter int WQ_DEPTH_POW2 = 2,
  parameter int RQ_DEPTH_POW2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CID_WIDTH-1:0]    wr_cid,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [CID_WIDTH-1:0]    rd_cid,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  output logic [CID_WIDTH-1:0]    biu_awcid,
  output logic [ADDR_WIDTH-1:0]   biu_awaddr,
  output logic [DATA_WIDTH-1:0]   biu_awdata,
  output logic [DATA_WIDTH/8-1:0] biu_awstrb,
  output logic                    biu_awvalid,
  input  logic                    biu_awpop,
  output logic [CID_WIDTH-1:0]    biu_arcid,
  output logic [ADDR_WIDTH-1:0]   biu_araddr,
  output logic                    biu_arvalid,
  input  logic                    biu_arpop,
  output logic                    wq_empty,
  output logic                    rq_empty,
  output logic                    err_uflow
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_WQ_W   = CID_WIDTH + ADDR_WIDTH + DATA_WIDTH + c_STRB_W;
  localparam int c_RQ_W   = CID_WIDTH + ADDR_WIDTH;

  logic [c_WQ_W-1:0] w_wq_in;
  logic [c_WQ_W-1:0] w_wq_head;
  logic [c_RQ_W-1:0] w_rq_in;
  logic [c_RQ_W-1:0] w_rq_head;
  logic              w_wq_uflow;
  logic              w_rq_uflow;
  logic              err_uflow_q, err_uflow_d;

  assign w_wq_in = {wr_cid, wr_addr, wr_data, wr_strb};
  assign w_rq_in = {rd_cid, rd_addr};

  vxe_axi4mas_reqq_fifo #(
    .WIDTH      (c_WQ_W),
    .DEPTH_POW2 (WQ_DEPTH_POW2)
  ) u_wq (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (wr_valid),
    .push_ready_o (wr_ready),
    .push_data_i  (w_wq_in),
    .pop_i        (biu_awpop),
    .head_data_o  (w_wq_head),
    .head_valid_o (biu_awvalid),
    .empty_o      (wq_empty),
    .uflow_o      (w_wq_uflow)
  );

  vxe_axi4mas_reqq_fifo #(
    .WIDTH      (c_RQ_W),
    .DEPTH_POW2 (RQ_DEPTH_POW2)
  ) u_rq (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (rd_valid),
    .push_ready_o (rd_ready),
    .push_data_i  (w_rq_in),
    .pop_i        (biu_arpop),
    .head_data_o  (w_rq_head),
    .head_valid_o (biu_arvalid),
    .empty_o      (rq_empty),
    .uflow_o      (w_rq_uflow)
  );

  assign {biu_awcid, biu_awaddr, biu_awdata, biu_awstrb} = w_wq_head;
  assign {biu_arcid, biu_araddr}                         = w_rq_head;

  assign err_uflow_d = err_uflow_q || w_wq_uflow || w_rq_uflow;
  assign err_uflow   = err_uflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_uflow_q <= 1'b0;
    end else begin
      err_uflow_q <= err_uflow_d;
    end
  end

endmodule

`default_nettype wire
